// File: rtl/pc_ctrl_unit_if.sv
// ============================================================================
//  Module      : pc_ctrl_unit_if
//  Description : Request/response bundle between the hazard unit / EX branch
//                logic (master) and the fetch-stage PC controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_ctrl_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  // Requests toward the controller
  logic             stall_req;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             halt_req;
  logic             resume;
  // Controls toward the fetch stage
  logic             pc_en;
  logic             pc_src;
  logic [WIDTH-1:0] pc_target;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             halted;
  logic             stall_timeout;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt_tot;

  modport master (
    output stall_req, branch_taken, branch_target, halt_req, resume,
    input  pc_en, pc_src, pc_target, flush_if_id, flush_id_ex, halted,
    input  stall_timeout, redirect_cnt, stall_cnt_tot
  );

  modport slave (
    input  stall_req, branch_taken, branch_target, halt_req, resume,
    output pc_en, pc_src, pc_target, flush_if_id, flush_id_ex, halted,
    output stall_timeout, redirect_cnt, stall_cnt_tot
  );
endinterface

`default_nettype wire

// File: rtl/pc_ctrl_unit.sv
// ============================================================================
//  Module      : pc_ctrl_unit
//  Description : Fetch-stage PC sequencer. Produces PC enable, PC mux select,
//                registered redirect target and IF/ID, ID/EX flush strobes
//                from stall, branch-resolution and halt requests.
//                Optional statistics counters: define PC_CTRL_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ctrl_unit #(
  parameter int WIDTH     = 32,
  parameter int STALL_MAX = 15,
  parameter int CNT_W     = 16
) (
  input  wire logic      clk,
  input  wire logic      rst,
  pc_ctrl_unit_if.slave  bus
);

  localparam int                STALL_W   = $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    REDIR = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   target_q;
  logic               load_target;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_cnt_nxt;
  logic               timeout_q;
  logic               timeout_nxt;

  logic pc_en;
  logic pc_src;
  logic flush_if_id;
  logic flush_id_ex;
  logic halted;

  // Next-state, counter update and combinational fetch controls
  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    timeout_nxt   = timeout_q;
    load_target   = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    halted        = 1'b0;

    case (state)
      // STALL with stall_req dropped falls through to the RUN rules in
      // the same cycle, so both states share one priority chain.
      RUN, STALL: begin
        if (bus.branch_taken) begin
          load_target   = 1'b1;
          flush_if_id   = 1'b1;
          flush_id_ex   = 1'b1;
          stall_cnt_nxt = '0;
          state_nxt     = REDIR;
        end else if (bus.stall_req) begin
          flush_id_ex = 1'b1;
          state_nxt   = STALL;
          if (state == RUN) begin
            stall_cnt_nxt = STALL_ONE;
          end else if (stall_cnt != STALL_LIM) begin
            stall_cnt_nxt = stall_cnt + STALL_ONE;
          end
          if (stall_cnt_nxt == STALL_LIM) begin
            timeout_nxt = 1'b1;
          end
        end else if (bus.halt_req) begin
          stall_cnt_nxt = '0;
          state_nxt     = HALT;
        end else begin
          pc_en         = 1'b1;
          stall_cnt_nxt = '0;
          state_nxt     = RUN;
        end
      end
      // One-cycle redirect; the instruction in EX is wrong-path, so its
      // stall/branch requests are not acted upon.
      REDIR: begin
        pc_en       = 1'b1;
        pc_src      = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_nxt   = bus.halt_req ? HALT : RUN;
      end
      HALT: begin
        halted = 1'b1;
        if (bus.resume) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    // Reset holds the pipeline front end flushed and frozen.
    if (rst) begin
      pc_en       = 1'b0;
      pc_src      = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      halted      = 1'b0;
    end
  end

  // State, redirect target, stall counter and sticky timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      target_q  <= '0;
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      timeout_q <= timeout_nxt;
      if (load_target) begin
        target_q <= bus.branch_target;
      end
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.pc_src      = pc_src;
  assign bus.pc_target   = target_q;
  assign bus.flush_if_id = flush_if_id;
  assign bus.flush_id_ex = flush_id_ex;
  assign bus.halted      = halted;
  // Timeout is visible during the stall cycle that reaches the limit.
  assign bus.stall_timeout = timeout_nxt & ~rst;

`ifdef PC_CTRL_STATS_EN
  logic [CNT_W-1:0] redirect_cnt_q;
  logic [CNT_W-1:0] stall_cnt_tot_q;

  // Redirect and stall-cycle statistics, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt_q  <= '0;
      stall_cnt_tot_q <= '0;
    end else begin
      if (state_nxt == REDIR) begin
        redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      end
      if (state == STALL) begin
        stall_cnt_tot_q <= stall_cnt_tot_q + CNT_W'(1);
      end
    end
  end

  assign bus.redirect_cnt  = redirect_cnt_q;
  assign bus.stall_cnt_tot = stall_cnt_tot_q;
`else
  assign bus.redirect_cnt  = '0;
  assign bus.stall_cnt_tot = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_ctrl_unit.sv
// ============================================================================
//  Module      : tb_pc_ctrl_unit
//  Description : Directed scoreboard bench for pc_ctrl_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_ctrl_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_ctrl_unit_if #(.WIDTH(32), .CNT_W(16)) bus ();

  pc_ctrl_unit #(.WIDTH(32), .STALL_MAX(15), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        en;
    logic        src;
    logic        fif;
    logic        fie;
    logic        hlt;
    logic        to;
    logic [31:0] tgt;
    logic [15:0] rc;
    logic [15:0] sc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Drive one cycle of inputs and queue the outputs expected in that cycle
  task automatic step(input logic r, s, b, input logic [31:0] t, input logic h, rs,
                      input logic en, src, fif, fie, hlt, to,
                      input logic [31:0] tg, input logic [15:0] rc, sc,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.stall_req     = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
    bus.halt_req      = h;
    bus.resume        = rs;
    e.en = en; e.src = src; e.fif = fif; e.fie = fie; e.hlt = hlt; e.to = to;
    e.tgt = tg; e.rc = rc; e.sc = sc; e.name = nm;
`ifndef PC_CTRL_STATS_EN
    e.rc = '0;
    e.sc = '0;
`endif
    sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.pc_en !== e.en || bus.pc_src !== e.src || bus.flush_if_id !== e.fif ||
          bus.flush_id_ex !== e.fie || bus.halted !== e.hlt || bus.stall_timeout !== e.to ||
          bus.pc_target !== e.tgt || bus.redirect_cnt !== e.rc || bus.stall_cnt_tot !== e.sc) begin
        failures++;
        $display("FAIL %s: got en=%b src=%b fif=%b fie=%b hlt=%b to=%b tgt=%h rc=%0d sc=%0d exp en=%b src=%b fif=%b fie=%b hlt=%b to=%b tgt=%h rc=%0d sc=%0d",
                 e.name, bus.pc_en, bus.pc_src, bus.flush_if_id, bus.flush_id_ex, bus.halted,
                 bus.stall_timeout, bus.pc_target, bus.redirect_cnt, bus.stall_cnt_tot,
                 e.en, e.src, e.fif, e.fie, e.hlt, e.to, e.tgt, e.rc, e.sc);
      end
    end
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    bus.stall_req     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.halt_req      = 1'b0;
    bus.resume        = 1'b0;

    //   r s b target    h rs  en src fif fie hlt to  tgt       rc sc
    step(1,0,0,32'h0,    0,0,  0,0,1,1,0,0, 32'h0,   0,0, "reset_a");
    step(1,0,0,32'h0,    0,0,  0,0,1,1,0,0, 32'h0,   0,0, "reset_b");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h0,   0,0, "run_idle");
    // Branch to 0x40
    step(0,0,1,32'h40,   0,0,  0,0,1,1,0,0, 32'h0,   0,0, "branch_n");
    step(0,0,0,32'h0,    0,0,  1,1,1,1,0,0, 32'h40,  1,0, "branch_n1");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h40,  1,0, "branch_n2");
    // Three-cycle stall
    step(0,1,0,32'h0,    0,0,  0,0,0,1,0,0, 32'h40,  1,0, "stall_c1");
    step(0,1,0,32'h0,    0,0,  0,0,0,1,0,0, 32'h40,  1,0, "stall_c2");
    step(0,1,0,32'h0,    0,0,  0,0,0,1,0,0, 32'h40,  1,1, "stall_c3");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h40,  1,2, "stall_release");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h40,  1,3, "stall_total");
    // Branch wins over simultaneous stall; stall ignored in REDIR
    step(0,1,1,32'h100,  0,0,  0,0,1,1,0,0, 32'h40,  1,3, "prio_n");
    step(0,1,0,32'h0,    0,0,  1,1,1,1,0,0, 32'h100, 2,3, "prio_redir");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h100, 2,3, "prio_run");
    // Back-to-back redirects
    step(0,0,1,32'h200,  0,0,  0,0,1,1,0,0, 32'h100, 2,3, "b2b_n_a");
    step(0,0,0,32'h0,    0,0,  1,1,1,1,0,0, 32'h200, 3,3, "b2b_redir_a");
    step(0,0,1,32'h300,  0,0,  0,0,1,1,0,0, 32'h200, 3,3, "b2b_n_b");
    step(0,0,0,32'h0,    0,0,  1,1,1,1,0,0, 32'h300, 4,3, "b2b_redir_b");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h300, 4,3, "b2b_run");
    // Branch taken while in STALL
    step(0,1,0,32'h0,    0,0,  0,0,0,1,0,0, 32'h300, 4,3, "stbr_stall");
    step(0,1,1,32'h400,  0,0,  0,0,1,1,0,0, 32'h300, 4,3, "stbr_branch");
    step(0,0,0,32'h0,    0,0,  1,1,1,1,0,0, 32'h400, 5,4, "stbr_redir");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h400, 5,4, "stbr_run");
    // Halt: requests ignored until resume
    step(0,0,0,32'h0,    1,0,  0,0,0,0,0,0, 32'h400, 5,4, "halt_req");
    step(0,0,1,32'h500,  0,0,  0,0,0,0,1,0, 32'h400, 5,4, "halt_ign_br");
    step(0,1,0,32'h0,    0,0,  0,0,0,0,1,0, 32'h400, 5,4, "halt_ign_stall");
    step(0,0,0,32'h0,    0,1,  0,0,0,0,1,0, 32'h400, 5,4, "halt_resume");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h400, 5,4, "halt_run");
    // REDIR followed by halt
    step(0,0,1,32'h600,  0,0,  0,0,1,1,0,0, 32'h400, 5,4, "rh_branch");
    step(0,0,0,32'h0,    1,0,  1,1,1,1,0,0, 32'h600, 6,4, "rh_redir");
    step(0,0,0,32'h0,    0,1,  0,0,0,0,1,0, 32'h600, 6,4, "rh_halt");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h600, 6,4, "rh_run");
    // Stall held 20 cycles: timeout from the 15th stall cycle
    for (int k = 1; k <= 20; k++) begin
      step(0,1,0,32'h0, 0,0, 0,0,0,1,0, (k >= 15) ? 1'b1 : 1'b0, 32'h600, 6,
           (k == 1) ? 16'd4 : 16'(k + 2), "timeout_hold");
    end
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,1, 32'h600, 6,23, "timeout_release");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,1, 32'h600, 6,24, "timeout_sticky");
    // Reset mid-STALL and mid-REDIR
    step(0,1,0,32'h0,    0,0,  0,0,0,1,0,1, 32'h600, 6,24, "rs_stall_a");
    step(0,1,0,32'h0,    0,0,  0,0,0,1,0,1, 32'h600, 6,24, "rs_stall_b");
    step(1,1,0,32'h0,    0,0,  0,0,1,1,0,0, 32'h0,   0,0, "reset_mid_stall");
    step(0,0,1,32'h700,  0,0,  0,0,1,1,0,0, 32'h0,   0,0, "rs_branch");
    step(1,0,0,32'h0,    0,0,  0,0,1,1,0,0, 32'h0,   0,0, "reset_mid_redir");
    step(0,0,0,32'h0,    0,0,  1,0,0,0,0,0, 32'h0,   0,0, "after_reset");

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expectations, exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
